relay_frame_tx: RTL and testbench

RELAY_FRAME_TX -- requirements
Module: relay_frame_tx

---
 rtl/relay_frame_tx_pkg.sv | 26 ++
 rtl/relay_slot_tick.sv | 29 ++
 rtl/relay_frame_tx.sv | 206 ++++++++++++++++++++
 tb/tb_relay_frame_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/relay_frame_tx_pkg.sv
// Shared relay definitions: start fields, END lengths, timing defaults and FSM encoding.
// Imported by both the transmit framer and the receive-side decoder.
package relay_frame_tx_pkg;

    localparam logic [7:0] START_READER     = 8'hC0;
    localparam logic [7:0] START_TAG        = 8'hF0;
    localparam int         END_SLOTS_READER = 24;
    localparam int         END_SLOTS_TAG    = 16;
    localparam int         GUARD_SLOTS_DEF  = 16;
    localparam logic [3:0] TICK_PHASE_DEF   = 4'b1000;
    localparam int         SLOT_CNT_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GUARD,
        ST_START,
        ST_DATA,
        ST_END
    } relay_state_e;

    // Manchester: a 1 is sent as (1,0), a 0 as (0,1).
    function automatic logic manch_slot(input logic bit_val, input logic second_half);
        return bit_val ^ second_half;
    endfunction

endpackage

// File: rtl/relay_slot_tick.sv
// Free-running 4-bit slot divider; tick is high for one clk when the divider hits TICK_PHASE.
// Zero latency from divider to tick, no backpressure; shared with the receive path.
module relay_slot_tick
    import relay_frame_tx_pkg::*;
#(
    parameter logic [3:0] TICK_PHASE = TICK_PHASE_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [3:0] div_q;
    logic [3:0] div_d;

    always_comb begin
        div_d = div_q + 4'd1;
        tick  = (div_q == TICK_PHASE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= 4'd0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/relay_frame_tx.sv
// Relay frame serializer: GUARD zeros, start field, Manchester payload, END zeros, one slot per tick.
// One-byte holding register; tx_ready drops while it is full, refilled back-to-back with no gap slot.
module relay_frame_tx
    import relay_frame_tx_pkg::*;
#(
    parameter int         GUARD_SLOTS = GUARD_SLOTS_DEF,
    parameter logic [3:0] TICK_PHASE  = TICK_PHASE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fake_reader,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       data_out,
    output logic       busy,
    output logic       underrun
);

    localparam int                GAP_W    = $clog2(GUARD_SLOTS + 1);
    localparam logic [GAP_W-1:0]  GAP_FULL = GAP_W'(GUARD_SLOTS);

    logic                  tick;
    relay_state_e          state_q, state_d;
    logic [SLOT_CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  rdr_q, rdr_d;
    logic [7:0]            cur_dat_q, cur_dat_d;
    logic                  cur_last_q, cur_last_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [7:0]            hold_dat_q, hold_dat_d;
    logic                  hold_last_q, hold_last_d;
    logic                  hold_rdr_q, hold_rdr_d;
    logic                  rdy_en_q, rdy_en_d;
    logic                  data_out_q, data_out_d;
    logic                  busy_q, busy_d;
    logic                  underrun_q, underrun_d;

    logic                  accept;
    logic                  unload;
    logic                  slot;
    logic                  new_rdr;
    logic [7:0]            start_pat;
    logic [SLOT_CNT_W-1:0] end_last_cnt;

    relay_slot_tick #(
        .TICK_PHASE (TICK_PHASE)
    ) u_slot_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign tx_ready = rdy_en_q && !hold_vld_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

    always_comb begin
        accept       = tx_valid && tx_ready;
        new_rdr      = hold_vld_q ? hold_rdr_q : fake_reader;
        start_pat    = rdr_q ? START_READER : START_TAG;
        end_last_cnt = rdr_q ? SLOT_CNT_W'(END_SLOTS_READER - 1) : SLOT_CNT_W'(END_SLOTS_TAG - 1);

        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        gap_d       = gap_q;
        rdr_d       = rdr_q;
        cur_dat_d   = cur_dat_q;
        cur_last_d  = cur_last_q;
        hold_vld_d  = hold_vld_q;
        hold_dat_d  = hold_dat_q;
        hold_last_d = hold_last_q;
        hold_rdr_d  = hold_rdr_q;
        rdy_en_d    = 1'b1;
        data_out_d  = data_out_q;
        busy_d      = (state_q != ST_IDLE);
        underrun_d  = 1'b0;
        unload      = 1'b0;
        slot        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept || hold_vld_q) begin
                    state_d = ST_GUARD;
                    rdr_d   = new_rdr;
                end
            end
            ST_GUARD: begin
                // A satisfied gap lets this very tick carry the first start slot.
                if (tick) begin
                    if (gap_q >= GAP_FULL) begin
                        state_d    = ST_START;
                        slot       = start_pat[7];
                        slot_cnt_d = SLOT_CNT_W'(1);
                        gap_d      = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            ST_START: begin
                if (tick) begin
                    slot = start_pat[3'd7 - slot_cnt_q[2:0]];
                    if (slot_cnt_q == SLOT_CNT_W'(7)) begin
                        state_d    = ST_DATA;
                        slot_cnt_d = '0;
                        unload     = 1'b1;
                    end else begin
                        slot_cnt_d = slot_cnt_q + SLOT_CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    slot = manch_slot(cur_dat_q[3'd7 - slot_cnt_q[3:1]], slot_cnt_q[0]);
                    if (slot_cnt_q == SLOT_CNT_W'(15)) begin
                        slot_cnt_d = '0;
                        if (cur_last_q) begin
                            state_d = ST_END;
                        end else if (hold_vld_q) begin
                            unload = 1'b1;
                        end else begin
                            state_d    = ST_END;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q + SLOT_CNT_W'(1);
                    end
                end
            end
            ST_END: begin
                if (tick) begin
                    if (gap_q != GAP_FULL) begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                    if (slot_cnt_q == end_last_cnt) begin
                        slot_cnt_d = '0;
                        if (accept || hold_vld_q) begin
                            state_d = ST_GUARD;
                            rdr_d   = new_rdr;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q + SLOT_CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tick) begin
            data_out_d = slot;
        end

        // Unload before store so a same-cycle refill is never lost.
        if (unload) begin
            hold_vld_d = 1'b0;
            cur_dat_d  = hold_dat_q;
            cur_last_d = hold_last_q;
        end
        if (accept) begin
            hold_vld_d  = 1'b1;
            hold_dat_d  = tx_data;
            hold_last_d = tx_last;
            hold_rdr_d  = fake_reader;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            slot_cnt_q  <= '0;
            gap_q       <= '0;
            rdr_q       <= 1'b0;
            cur_dat_q   <= 8'd0;
            cur_last_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_dat_q  <= 8'd0;
            hold_last_q <= 1'b0;
            hold_rdr_q  <= 1'b0;
            rdy_en_q    <= 1'b0;
            data_out_q  <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            gap_q       <= gap_d;
            rdr_q       <= rdr_d;
            cur_dat_q   <= cur_dat_d;
            cur_last_q  <= cur_last_d;
            hold_vld_q  <= hold_vld_d;
            hold_dat_q  <= hold_dat_d;
            hold_last_q <= hold_last_d;
            hold_rdr_q  <= hold_rdr_d;
            rdy_en_q    <= rdy_en_d;
            data_out_q  <= data_out_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_relay_frame_tx.sv
// Directed bench for relay_frame_tx: slot streams captured one per tick and compared to hand-coded vectors.
module tb_relay_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       fake_reader;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       data_out;
    logic       busy;
    logic       underrun;

    logic [3:0]   tb_div;
    logic [127:0] stream;
    int           n_checks = 0;
    int           n_fail   = 0;

    relay_frame_tx dut (
        .clk         (clk),
        .reset       (reset),
        .fake_reader (fake_reader),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .data_out    (data_out),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Reference slot divider: the tick edge is the one that takes it from 8 to 9.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_div <= 4'd0;
        else        tb_div <= tb_div + 4'd1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic get_slot(output logic s);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tb_div != 4'd9 && waited < 40);
        if (tb_div != 4'd9) begin
            n_checks++; n_fail++;
            $display("FAIL slot_wait: no tick seen within 40 clk");
        end
        s = data_out;
    endtask

    task automatic capture(input int n);
        logic s;
        for (int i = 0; i < n; i++) begin
            get_slot(s);
            stream = {stream[126:0], s};
        end
    endtask

    task automatic push(input logic [7:0] d, input logic last, input logic rdr, input logic align);
        int waited;
        waited = 0;
        if (align) begin
            do @(negedge clk); while (tb_div != 4'd2);
        end else begin
            @(negedge clk);
        end
        tx_valid    = 1'b1;
        tx_data     = d;
        tx_last     = last;
        fake_reader = rdr;
        while (!tx_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: byte %h never accepted, tx_ready=%b", d, tx_ready);
        end
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'd0; tx_last = 1'b0; fake_reader = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL rst_data_out: got %b want 0", data_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ready: got %b want 0", tx_ready); end
        reset = 1'b1;
        #1;
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready: got %b want 0", tx_ready); end
        @(posedge clk); #1;
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise: got %b want 1", tx_ready); end
    endtask

    task automatic test_reader_single;
        stream = '0;
        push(8'hA5, 1'b1, 1'b1, 1'b1);
        capture(1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy_mid: got %b want 1", busy); end
        capture(63);
        n_checks++; if (stream[63:48] !== 16'h0000) begin n_fail++; $display("FAIL rd_guard: got %h want 0000", stream[63:48]); end
        n_checks++; if (stream[47:40] !== 8'hC0) begin n_fail++; $display("FAIL rd_start: got %h want c0", stream[47:40]); end
        n_checks++; if (stream[39:24] !== 16'h9966) begin n_fail++; $display("FAIL rd_data: got %h want 9966", stream[39:24]); end
        n_checks++; if (stream[23:0] !== 24'h000000) begin n_fail++; $display("FAIL rd_end: got %h want 000000", stream[23:0]); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy_last_end: got %b want 1", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_fall: got %b want 0", busy); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rd_idle_ready: got %b want 1", tx_ready); end
    endtask

    task automatic test_tag_two;
        stream = '0;
        push(8'h00, 1'b0, 1'b0, 1'b1);
        fork
            push(8'hFF, 1'b1, 1'b0, 1'b0);
            capture(56);
        join
        n_checks++; if (stream[55:48] !== 8'hF0) begin n_fail++; $display("FAIL tag_start: got %h want f0", stream[55:48]); end
        n_checks++; if (stream[47:32] !== 16'h5555) begin n_fail++; $display("FAIL tag_byte0: got %h want 5555", stream[47:32]); end
        n_checks++; if (stream[31:16] !== 16'hAAAA) begin n_fail++; $display("FAIL tag_byte1: got %h want aaaa", stream[31:16]); end
        n_checks++; if (stream[15:0] !== 16'h0000) begin n_fail++; $display("FAIL tag_end: got %h want 0000", stream[15:0]); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tag_busy_last_end: got %b want 1", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tag_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_underrun;
        stream = '0;
        push(8'h3C, 1'b0, 1'b1, 1'b1);
        capture(23);
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_early: got %b want 0", underrun); end
        capture(1);
        n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_pulse: got %b want 1", underrun); end
        @(negedge clk);
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_single: got %b want 0", underrun); end
        capture(24);
        n_checks++; if (stream[47:40] !== 8'hC0) begin n_fail++; $display("FAIL ur_start: got %h want c0", stream[47:40]); end
        n_checks++; if (stream[39:24] !== 16'h5AA5) begin n_fail++; $display("FAIL ur_data: got %h want 5aa5", stream[39:24]); end
        n_checks++; if (stream[23:0] !== 24'h000000) begin n_fail++; $display("FAIL ur_end: got %h want 000000", stream[23:0]); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ur_busy_last_end: got %b want 1", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ur_end_len: busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        stream = '0;
        push(8'h81, 1'b1, 1'b1, 1'b1);
        capture(26);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_end_ready: got %b want 1", tx_ready); end
        push(8'h42, 1'b1, 1'b0, 1'b0);
        capture(22);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_hold: got %b want 1", busy); end
        capture(40);
        n_checks++; if (stream[87:80] !== 8'hC0) begin n_fail++; $display("FAIL b2b_start1: got %h want c0", stream[87:80]); end
        n_checks++; if (stream[79:64] !== 16'h9556) begin n_fail++; $display("FAIL b2b_data1: got %h want 9556", stream[79:64]); end
        n_checks++; if (stream[63:40] !== 24'h000000) begin n_fail++; $display("FAIL b2b_end1: got %h want 000000", stream[63:40]); end
        n_checks++; if (stream[39:32] !== 8'hF0) begin n_fail++; $display("FAIL b2b_start2: got %h want f0", stream[39:32]); end
        n_checks++; if (stream[31:16] !== 16'h6559) begin n_fail++; $display("FAIL b2b_data2: got %h want 6559", stream[31:16]); end
        n_checks++; if (stream[15:0] !== 16'h0000) begin n_fail++; $display("FAIL b2b_end2: got %h want 0000", stream[15:0]); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_tick_timing;
        logic prev;
        int   last_t;
        int   transitions;
        push(8'hA5, 1'b1, 1'b1, 1'b1);
        prev        = data_out;
        last_t      = -1;
        transitions = 0;
        for (int c = 0; c < 60 * 16; c++) begin
            @(negedge clk);
            if (data_out !== prev) begin
                n_checks++;
                if (tb_div !== 4'd9) begin
                    n_fail++;
                    $display("FAIL tick_phase: transition with divider now %0d want 9", tb_div);
                end
                if (last_t >= 0) begin
                    n_checks++;
                    if ((c - last_t) % 16 != 0) begin
                        n_fail++;
                        $display("FAIL tick_spacing: %0d clk between transitions, want multiple of 16", c - last_t);
                    end
                end
                last_t = c;
                transitions++;
                prev = data_out;
            end
        end
        n_checks++; if (transitions != 12) begin n_fail++; $display("FAIL tick_count: got %0d transitions want 12", transitions); end
    endtask

    task automatic test_reset_mid_data;
        push(8'hFF, 1'b0, 1'b1, 1'b1);
        capture(9);
        push(8'h12, 1'b1, 1'b1, 1'b0);
        capture(4);
        n_checks++; if (data_out !== 1'b1) begin n_fail++; $display("FAIL mid_slot5: got %b want 1", data_out); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL mid_hold_full: got %b want 0", tx_ready); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_data: got %b want 0", data_out); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", tx_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_rise: got %b want 1", tx_ready); end
        stream = '0;
        push(8'hC3, 1'b1, 1'b0, 1'b1);
        capture(56);
        n_checks++; if (stream[55:40] !== 16'h0000) begin n_fail++; $display("FAIL mid_guard: got %h want 0000", stream[55:40]); end
        n_checks++; if (stream[39:32] !== 8'hF0) begin n_fail++; $display("FAIL mid_start: got %h want f0", stream[39:32]); end
        n_checks++; if (stream[31:16] !== 16'hA55A) begin n_fail++; $display("FAIL mid_data: got %h want a55a", stream[31:16]); end
        n_checks++; if (stream[15:0] !== 16'h0000) begin n_fail++; $display("FAIL mid_end: got %h want 0000", stream[15:0]); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_fall: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_reader_single();
        test_tag_two();
        test_underrun();
        test_back_to_back();
        test_tick_timing();
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
